// File: rtl/riscv_axi4lite_arbiter.sv
// riscv_axi4lite_arbiter
//
// Shares the core's single AXI4-Lite master port between the instruction
// fetch unit (requester 0, read only) and the load/store unit (requester 1,
// read and write). Arbitration is round-robin over three request sources
// (fetch read, LSU read, LSU write) with only one transaction in flight at a
// time. Read data and write responses pass straight through to the owner.
//
// Ports
//   axi_clk, axi_arstn     clock, synchronous active-low reset
//   s0_ar*, s0_r*          fetch read address / read data channels
//   s1_ar*, s1_r*          LSU read address / read data channels
//   s1_aw*, s1_w*, s1_b*   LSU write address / write data / response channels
//   m_ar*, m_r*            master read address / read data channels
//   m_aw*, m_w*, m_b*      master write address / write data / response channels
module riscv_axi4lite_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  axi_clk,
    input  logic                  axi_arstn,
    // fetch port
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    // LSU port
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [STRB_WIDTH-1:0] s1_wstrb,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    // master port
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B} state_t;
    typedef enum logic [1:0] {SRC_R0, SRC_R1, SRC_W1} src_t;

    state_t state;
    src_t   last_src;   // most recently granted source, lowest priority next
    logic   rd_owner;   // 0: fetch owns the read, 1: LSU owns the read
    logic   aw_done;
    logic   w_done;

    logic req_r0, req_r1, req_w1;
    logic grant_r0, grant_r1, grant_w1;
    logic aw_hs, w_hs;

    assign req_r0 = s0_arvalid;
    assign req_r1 = s1_arvalid;
    // A write only competes once both its address and data are offered.
    assign req_w1 = s1_awvalid && s1_wvalid;

    // Round-robin: scan starting from the source after the last grant.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        grant_r0 = 1'b0;
        grant_r1 = 1'b0;
        grant_w1 = 1'b0;
        if (axi_arstn && state == ST_IDLE) begin
            case (last_src)
                SRC_R0: begin
                    if      (req_r1) grant_r1 = 1'b1;
                    else if (req_w1) grant_w1 = 1'b1;
                    else if (req_r0) grant_r0 = 1'b1;
                end
                SRC_R1: begin
                    if      (req_w1) grant_w1 = 1'b1;
                    else if (req_r0) grant_r0 = 1'b1;
                    else if (req_r1) grant_r1 = 1'b1;
                end
                default: begin
                    if      (req_r0) grant_r0 = 1'b1;
                    else if (req_r1) grant_r1 = 1'b1;
                    else if (req_w1) grant_w1 = 1'b1;
                end
            endcase
        end
    end

    assign s0_arready = grant_r0;
    assign s1_arready = grant_r1;
    assign s1_awready = grant_w1;
    assign s1_wready  = grant_w1;

    // Read data path: data is shared, only the owner sees rvalid.
    assign s0_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rdata  = m_rdata;
    assign s1_rresp  = m_rresp;
    assign s0_rvalid = (state == ST_R) && !rd_owner && m_rvalid;
    assign s1_rvalid = (state == ST_R) &&  rd_owner && m_rvalid;
    assign m_rready  = (state == ST_R) && (rd_owner ? s1_rready : s0_rready);

    // Write response path.
    assign s1_bresp  = m_bresp;
    assign s1_bvalid = (state == ST_B) && m_bvalid;
    assign m_bready  = (state == ST_B) && s1_bready;

    assign m_awprot  = 3'b000;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid  && m_wready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge axi_clk) begin
        if (!axi_arstn) begin
            state     <= ST_IDLE;
            last_src  <= SRC_W1;
            rd_owner  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            m_arvalid <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_araddr  <= '0;
            m_arprot  <= '0;
            m_awaddr  <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_r0) begin
                        m_araddr  <= s0_araddr;
                        m_arprot  <= 3'b100;   // instruction access
                        rd_owner  <= 1'b0;
                        last_src  <= SRC_R0;
                        m_arvalid <= 1'b1;
                        state     <= ST_AR;
                    end else if (grant_r1) begin
                        m_araddr  <= s1_araddr;
                        m_arprot  <= 3'b000;
                        rd_owner  <= 1'b1;
                        last_src  <= SRC_R1;
                        m_arvalid <= 1'b1;
                        state     <= ST_AR;
                    end else if (grant_w1) begin
                        m_awaddr  <= s1_awaddr;
                        m_wdata   <= s1_wdata;
                        m_wstrb   <= s1_wstrb;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        last_src  <= SRC_W1;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= ST_AWW;
                    end
                end
                ST_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_rvalid && m_rready) state <= ST_IDLE;
                end
                ST_AWW: begin
                    // AW and W complete independently; leave once both have.
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_B;
                end
                ST_B: begin
                    if (m_bvalid && s1_bready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_axi4lite_arbiter.sv
module tb_riscv_axi4lite_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;

    logic axi_clk = 1'b0;
    logic axi_arstn;
    always #5 axi_clk = ~axi_clk;

    logic [AW-1:0] s0_araddr, s1_araddr, s1_awaddr, m_araddr, m_awaddr;
    logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [DW-1:0] s0_rdata, s1_rdata, s1_wdata, m_rdata, m_wdata;
    logic [1:0]    s0_rresp, s1_rresp, s1_bresp, m_rresp, m_bresp;
    logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic          s1_awvalid, s1_awready, s1_wvalid, s1_wready;
    logic [SW-1:0] s1_wstrb, m_wstrb;
    logic          s1_bvalid, s1_bready;
    logic [2:0]    m_arprot, m_awprot;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic          m_awvalid, m_awready, m_wvalid, m_wready;
    logic          m_bvalid, m_bready;

    riscv_axi4lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .axi_clk(axi_clk), .axi_arstn(axi_arstn),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    // ---------------- bench state (all written by the single main process)
    int            n_checks, n_pass;
    // requesters: outstanding request counts and next payloads
    int            n_r0, n_r1, n_w1;
    logic [AW-1:0] a_r0, a_r1, a_w1;
    logic [DW-1:0] wd_w1;
    logic [SW-1:0] ws_w1;
    // slave configuration and state
    int            ar_lat, aw_lat, w_lat, r_lat, b_lat;
    logic [DW-1:0] rdata_cfg;
    logic [1:0]    rresp_cfg, bresp_cfg;
    int            ar_cnt, aw_cnt, w_cnt, r_wait, b_wait, rd_serial;
    bit            aw_got, w_got, rd_out, b_out;
    // observations
    int            cyc, r0_done, r1_done, w1_done;
    int            grant_cyc0, rvalid_cyc0, s1_rvalid_cycles, awv_cycles, wv_cycles;
    logic [DW-1:0] got_rdata0, cap_wdata;
    logic [AW-1:0] cap_araddr, cap_awaddr;
    logic [SW-1:0] cap_wstrb;
    logic [2:0]    cap_arprot;
    logic [1:0]    got_rresp0, got_rresp1, got_bresp;
    int            grant_log[$];
    int            exp_rot[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    // transaction-level model: who owns the port and what is still pending
    bit            model_valid;
    int            mdl_owner;      // -1 none, 0 fetch read, 1 LSU read, 2 LSU write
    int            mdl_last;       // last granted source index
    bit            mdl_addr_phase, mdl_aw_pend, mdl_w_pend;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wd;
    logic [SW-1:0] mdl_ws;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic bit cand(input int s);
        case (s)
            0:       return s0_arvalid;
            1:       return s1_arvalid;
            default: return s1_awvalid && s1_wvalid;
        endcase
    endfunction

    // Next source to win: first requesting one after the last winner.
    function automatic int pick_winner();
        if (!axi_arstn || mdl_owner >= 0) return -1;
        for (int k = 1; k <= 3; k++)
            if (cand((mdl_last + k) % 3)) return (mdl_last + k) % 3;
        return -1;
    endfunction

    task automatic model_compare();
        int win;
        bit is_rd, rd_addr, rd_data, wr_b, exp_rready;
        if (!model_valid) return;
        win     = pick_winner();
        is_rd   = (mdl_owner == 0) || (mdl_owner == 1);
        rd_addr = is_rd && mdl_addr_phase;
        rd_data = is_rd && !mdl_addr_phase;
        wr_b    = (mdl_owner == 2) && !mdl_aw_pend && !mdl_w_pend;
        exp_rready = rd_data && ((mdl_owner == 0) ? s0_rready : s1_rready);
        check("s0_arready", 64'(s0_arready), 64'(win == 0));
        check("s1_arready", 64'(s1_arready), 64'(win == 1));
        check("s1_awready", 64'(s1_awready), 64'(win == 2));
        check("s1_wready",  64'(s1_wready),  64'(win == 2));
        check("m_arvalid",  64'(m_arvalid),  64'(rd_addr));
        check("m_awvalid",  64'(m_awvalid),  64'(mdl_owner == 2 && mdl_aw_pend));
        check("m_wvalid",   64'(m_wvalid),   64'(mdl_owner == 2 && mdl_w_pend));
        check("s0_rvalid",  64'(s0_rvalid),  64'(rd_data && mdl_owner == 0 && m_rvalid));
        check("s1_rvalid",  64'(s1_rvalid),  64'(rd_data && mdl_owner == 1 && m_rvalid));
        check("m_rready",   64'(m_rready),   64'(exp_rready));
        check("s1_bvalid",  64'(s1_bvalid),  64'(wr_b && m_bvalid));
        check("m_bready",   64'(m_bready),   64'(wr_b && s1_bready));
        check("m_awprot",   64'(m_awprot),   64'd0);
        if (rd_addr) begin
            check("m_araddr", m_araddr, mdl_addr);
            check("m_arprot", 64'(m_arprot), (mdl_owner == 0) ? 64'd4 : 64'd0);
        end
        if (mdl_owner == 2 && mdl_aw_pend) check("m_awaddr", m_awaddr, mdl_addr);
        if (mdl_owner == 2 && mdl_w_pend) begin
            check("m_wdata", m_wdata, mdl_wd);
            check("m_wstrb", 64'(m_wstrb), 64'(mdl_ws));
        end
        if (rd_data && mdl_owner == 0 && m_rvalid) begin
            check("s0_rdata", s0_rdata, m_rdata);
            check("s0_rresp", 64'(s0_rresp), 64'(m_rresp));
        end
        if (rd_data && mdl_owner == 1 && m_rvalid) begin
            check("s1_rdata", s1_rdata, m_rdata);
            check("s1_rresp", 64'(s1_rresp), 64'(m_rresp));
        end
        if (wr_b && m_bvalid) check("s1_bresp", 64'(s1_bresp), 64'(m_bresp));
    endtask

    task automatic model_step();
        int win;
        if (!axi_arstn) begin
            mdl_owner = -1; mdl_last = 2;
            mdl_addr_phase = 0; mdl_aw_pend = 0; mdl_w_pend = 0;
            model_valid = 1;
            return;
        end
        if (!model_valid) return;
        win = pick_winner();
        if (win >= 0) begin
            mdl_owner = win;
            mdl_last  = win;
            if (win == 0)      begin mdl_addr = s0_araddr; mdl_addr_phase = 1; end
            else if (win == 1) begin mdl_addr = s1_araddr; mdl_addr_phase = 1; end
            else begin
                mdl_addr = s1_awaddr; mdl_wd = s1_wdata; mdl_ws = s1_wstrb;
                mdl_aw_pend = 1; mdl_w_pend = 1;
            end
        end else if (mdl_owner == 0 || mdl_owner == 1) begin
            if (mdl_addr_phase) begin
                if (m_arready) mdl_addr_phase = 0;
            end else if (m_rvalid && ((mdl_owner == 0) ? s0_rready : s1_rready)) begin
                mdl_owner = -1;
            end
        end else if (mdl_owner == 2) begin
            if (mdl_aw_pend || mdl_w_pend) begin
                if (m_awready) mdl_aw_pend = 0;
                if (m_wready)  mdl_w_pend  = 0;
            end else if (m_bvalid && s1_bready) begin
                mdl_owner = -1;
            end
        end
    endtask

    // Handshake bookkeeping for requesters and the slave, on pre-edge values.
    task automatic bookkeep();
        if (s1_rvalid) s1_rvalid_cycles++;
        if (m_awvalid) awv_cycles++;
        if (m_wvalid)  wv_cycles++;
        if (!axi_arstn) begin
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            rd_out = 0; b_out = 0; aw_got = 0; w_got = 0;
            return;
        end
        if (s0_arvalid && s0_arready) begin
            n_r0--; a_r0 += 64'd8; grant_log.push_back(0); grant_cyc0 = cyc;
        end
        if (s1_arvalid && s1_arready) begin
            n_r1--; a_r1 += 64'd8; grant_log.push_back(1);
        end
        if (s1_awvalid && s1_awready && s1_wvalid && s1_wready) begin
            n_w1--; a_w1 += 64'd8; wd_w1 += 64'd1; grant_log.push_back(2);
        end
        if (s0_rvalid && rvalid_cyc0 < 0) rvalid_cyc0 = cyc;
        if (s0_rvalid && s0_rready) begin r0_done++; got_rdata0 = s0_rdata; got_rresp0 = s0_rresp; end
        if (s1_rvalid && s1_rready) begin r1_done++; got_rresp1 = s1_rresp; end
        if (s1_bvalid && s1_bready) begin w1_done++; got_bresp = s1_bresp; end
        // slave
        if (m_arvalid && m_arready) begin
            rd_out = 1; r_wait = r_lat; cap_araddr = m_araddr; cap_arprot = m_arprot;
        end
        ar_cnt = (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
        if (m_rvalid && m_rready) begin rd_out = 0; rd_serial++; end
        else if (rd_out && r_wait > 0) r_wait--;
        if (m_awvalid && m_awready) begin aw_got = 1; cap_awaddr = m_awaddr; end
        if (m_wvalid && m_wready) begin w_got = 1; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
        aw_cnt = (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
        w_cnt  = (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
        if (m_bvalid && m_bready) b_out = 0;
        else if (b_out && b_wait > 0) b_wait--;
        if (aw_got && w_got) begin b_out = 1; b_wait = b_lat; aw_got = 0; w_got = 0; end
    endtask

    task automatic drive();
        s0_arvalid = (n_r0 > 0); s0_araddr = a_r0;
        s1_arvalid = (n_r1 > 0); s1_araddr = a_r1;
        s1_awvalid = (n_w1 > 0); s1_wvalid = (n_w1 > 0);
        s1_awaddr  = a_w1; s1_wdata = wd_w1; s1_wstrb = ws_w1;
        m_arready  = m_arvalid && (ar_cnt >= ar_lat);
        m_awready  = m_awvalid && !aw_got && (aw_cnt >= aw_lat);
        m_wready   = m_wvalid && !w_got && (w_cnt >= w_lat);
        m_rvalid   = rd_out && (r_wait == 0);
        m_rdata    = rdata_cfg + 64'(rd_serial);
        m_rresp    = rresp_cfg;
        m_bvalid   = b_out && (b_wait == 0);
        m_bresp    = bresp_cfg;
    endtask

    task automatic tick();
        @(negedge axi_clk);
        cyc++;
        model_compare();
        bookkeep();
        model_step();
        @(posedge axi_clk);
        #1;
        drive();
    endtask

    task automatic wait_for(input int e0, input int e1, input int e2, input string name);
        for (int k = 0; k < 400 && !(r0_done >= e0 && r1_done >= e1 && w1_done >= e2); k++) tick();
        check(name, 64'(r0_done >= e0 && r1_done >= e1 && w1_done >= e2), 64'd1);
    endtask

    initial begin
        int b0, b1, b2, max_wait, others;
        logic [DW-1:0] hold;
        n_checks = 0; n_pass = 0; cyc = 0; model_valid = 0;
        mdl_owner = -1; mdl_last = 2;
        n_r0 = 0; n_r1 = 0; n_w1 = 0;
        a_r0 = '0; a_r1 = '0; a_w1 = '0; wd_w1 = '0; ws_w1 = '0;
        ar_lat = 0; aw_lat = 0; w_lat = 0; r_lat = 0; b_lat = 0;
        rdata_cfg = '0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0; b_wait = 0; rd_serial = 0;
        aw_got = 0; w_got = 0; rd_out = 0; b_out = 0;
        r0_done = 0; r1_done = 0; w1_done = 0;
        grant_cyc0 = 0; rvalid_cyc0 = -1;
        s0_rready = 1'b1; s1_rready = 1'b1; s1_bready = 1'b1;
        axi_arstn = 1'b0;
        drive();
        repeat (3) tick();

        // reset state
        check("rst_m_araddr", m_araddr, 64'd0);
        check("rst_m_awaddr", m_awaddr, 64'd0);
        check("rst_m_wdata",  m_wdata,  64'd0);
        check("rst_m_wstrb",  64'(m_wstrb),  64'd0);
        check("rst_m_arprot", 64'(m_arprot), 64'd0);
        check("rst_valids",   64'({m_arvalid, m_awvalid, m_wvalid, s0_rvalid, s1_rvalid, s1_bvalid}), 64'd0);

        // single fetch
        rdata_cfg = 64'h0000_0013_0000_0013; rd_serial = 0;
        a_r0 = 64'h8000_0000; n_r0 = 1;
        s1_rvalid_cycles = 0; rvalid_cyc0 = -1;
        axi_arstn = 1'b1;
        wait_for(1, 0, 0, "fetch_done");
        check("fetch_araddr", cap_araddr, 64'h8000_0000);
        check("fetch_arprot", 64'(cap_arprot), 64'd4);
        check("fetch_rdata",  got_rdata0, 64'h0000_0013_0000_0013);
        check("fetch_rresp",  64'(got_rresp0), 64'd0);
        check("fetch_s1_rvalid_quiet", 64'(s1_rvalid_cycles), 64'd0);
        check("fetch_latency", 64'(rvalid_cyc0 - grant_cyc0), 64'd2);

        // write with skewed AW/W acceptance and SLVERR
        aw_lat = 0; w_lat = 3; b_lat = 1; bresp_cfg = 2'b10;
        a_w1 = 64'h1000; wd_w1 = 64'hdead_beef_cafe_f00d; ws_w1 = 8'h0f;
        awv_cycles = 0; wv_cycles = 0;
        n_w1 = 1;
        wait_for(1, 0, 1, "write_done");
        check("write_awvalid_cycles", 64'(awv_cycles), 64'd1);
        check("write_wvalid_cycles",  64'(wv_cycles),  64'd4);
        check("write_bresp",  64'(got_bresp), 64'd2);
        check("write_awaddr", cap_awaddr, 64'h1000);
        check("write_wdata",  cap_wdata, 64'hdead_beef_cafe_f00d);
        check("write_wstrb",  64'(cap_wstrb), 64'h0f);

        // LSU read under requester backpressure, DECERR passed through
        w_lat = 0; b_lat = 0; bresp_cfg = 2'b00;
        rdata_cfg = 64'h1111_2222_3333_4444; rresp_cfg = 2'b11; rd_serial = 0;
        a_r1 = 64'h2000; s1_rready = 1'b0; n_r1 = 1;
        for (int k = 0; k < 20 && !s1_rvalid; k++) tick();
        check("bp_rvalid_seen", 64'(s1_rvalid), 64'd1);
        hold = s1_rdata;
        check("bp_rdata_value", hold, 64'h1111_2222_3333_4444);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_m_rready", 64'(m_rready), 64'd0);
            check("bp_s1_rvalid", 64'(s1_rvalid), 64'd1);
            check("bp_rdata_stable", s1_rdata, hold);
        end
        s1_rready = 1'b1;
        wait_for(1, 1, 1, "bp_done");
        check("bp_rresp", 64'(got_rresp1), 64'd3);
        rresp_cfg = 2'b00;

        // contention: all three sources held from reset
        axi_arstn = 1'b0;
        n_r0 = 3; n_r1 = 3; n_w1 = 3;
        repeat (2) tick();
        grant_log.delete();
        b0 = r0_done; b1 = r1_done; b2 = w1_done;
        r_lat = 1; aw_lat = 1;
        axi_arstn = 1'b1;
        wait_for(b0 + 3, b1 + 3, b2 + 3, "contention_done");
        check("rot_count", 64'(grant_log.size()), 64'd9);
        for (int i = 0; i < 9 && i < grant_log.size(); i++)
            check("rot_order", 64'(grant_log[i]), 64'(exp_rot[i]));
        max_wait = 0;
        for (int i = 0; i < grant_log.size(); i++) begin
            others = i;
            for (int j = i - 1; j >= 0; j--)
                if (grant_log[j] == grant_log[i]) begin others = i - j - 1; break; end
            if (others > max_wait) max_wait = others;
        end
        check("max_wait", 64'(max_wait), 64'd2);

        // reset while a fetch read is waiting for data
        r_lat = 10; aw_lat = 0;
        a_r0 = 64'h3000; n_r0 = 1;
        for (int k = 0; k < 20 && !rd_out; k++) tick();
        check("midr_read_issued", 64'(rd_out), 64'd1);
        repeat (2) tick();
        axi_arstn = 1'b0;
        n_r0 = 1; n_r1 = 1;
        tick();
        check("midr_valids", 64'({m_arvalid, m_awvalid, m_wvalid, s0_rvalid, s1_rvalid, s1_bvalid}), 64'd0);
        check("midr_readies", 64'({s0_arready, s1_arready, s1_awready, s1_wready, m_rready, m_bready}), 64'd0);
        grant_log.delete();
        b0 = r0_done; b1 = r1_done;
        r_lat = 0;
        axi_arstn = 1'b1;
        wait_for(b0 + 1, b1 + 1, w1_done, "midr_after_done");
        check("midr_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            check("midr_first_grant",  64'(grant_log[0]), 64'd0);
            check("midr_second_grant", 64'(grant_log[1]), 64'd1);
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_axi4lite_arbiter.md
# riscv_axi4lite_arbiter

Shares the core's single AXI4-Lite master port between two requesters: requester 0 (instruction fetch, read-only) and requester 1 (load/store unit, read and write). Fair round-robin grant, one transaction in flight at a time, and pass-through of data and response channels to the granted requester. Sits between the fetch/LSU ports and the AXI4-Lite bridge that leads to the system interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width of all ports
- DATA_WIDTH, 64, data width of all ports
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- axi_clk  in  1  clock; all logic samples on the rising edge
- axi_arstn  in  1  synchronous active-low reset
- s0_araddr  in  ADDR_WIDTH  fetch read address
- s0_arvalid / s0_arready  in / out  1 / 1  fetch AR handshake
- s0_rdata / s0_rresp  out  DATA_WIDTH / 2  fetch read data and response
- s0_rvalid / s0_rready  out / in  1 / 1  fetch R handshake
- s1_araddr  in  ADDR_WIDTH  LSU read address
- s1_arvalid / s1_arready  in / out  1 / 1  LSU AR handshake
- s1_rdata / s1_rresp  out  DATA_WIDTH / 2  LSU read data and response
- s1_rvalid / s1_rready  out / in  1 / 1  LSU R handshake
- s1_awaddr  in  ADDR_WIDTH  LSU write address
- s1_awvalid / s1_awready  in / out  1 / 1  LSU AW handshake
- s1_wdata / s1_wstrb  in  DATA_WIDTH / STRB_WIDTH  LSU write data and strobes
- s1_wvalid / s1_wready  in / out  1 / 1  LSU W handshake
- s1_bresp  out  2  LSU write response
- s1_bvalid / s1_bready  out / in  1 / 1  LSU B handshake
- m_araddr / m_arprot  out  ADDR_WIDTH / 3  master read address and protection
- m_arvalid / m_arready  out / in  1 / 1  master AR handshake
- m_rdata / m_rresp  in  DATA_WIDTH / 2  master read data and response
- m_rvalid / m_rready  in / out  1 / 1  master R handshake
- m_awaddr / m_awprot  out  ADDR_WIDTH / 3  master write address and protection
- m_awvalid / m_awready  out / in  1 / 1  master AW handshake
- m_wdata / m_wstrb  out  DATA_WIDTH / STRB_WIDTH  master write data and strobes
- m_wvalid / m_wready  out / in  1 / 1  master W handshake
- m_bresp  in  2  master write response
- m_bvalid / m_bready  in / out  1 / 1  master B handshake

## Operation
- Request sources:
  - R0 = s0_arvalid
  - R1 = s1_arvalid
  - W1 = s1_awvalid && s1_wvalid. A write is not a candidate until both AW and W are valid.
- FSM states: IDLE, AR, R, AWW, B.
- IDLE, arbitration:
  - Round-robin over the order R0 → R1 → W1, starting after the last-granted source. The granted source becomes lowest priority.
  - After reset the last-granted source is W1, so the initial priority is R0 > R1 > W1.
- IDLE, grant:
  - The winner's ready is asserted combinationally in the same cycle (s0_arready, s1_arready, or s1_awready and s1_wready together).
  - Address, wdata and wstrb are registered on that handshake.
  - A read grant moves to AR; a write grant moves to AWW.
- m_arprot = 3'b100 for R0 (instruction access); m_arprot = 3'b000 for R1. m_awprot = 3'b000.
- AR: m_arvalid = 1 until m_arready, then go to R.
- R:
  - m_rdata, m_rresp and m_rvalid pass combinationally to the granted requester's r* outputs.
  - m_rready = the granted requester's rready.
  - The other requester's rvalid = 0.
  - On m_rvalid && m_rready, go to IDLE.
- AWW:
  - m_awvalid and m_wvalid are asserted together.
  - Each drops independently after its own handshake. A done flag per channel records completion.
  - When both are done, go to B. Both handshakes in the same cycle is legal and goes straight to B.
- B:
  - s1_bvalid = m_bvalid, s1_bresp = m_bresp, m_bready = s1_bready.
  - On the handshake, go to IDLE.
- Responses (SLVERR/DECERR) pass through unmodified. The arbiter never generates responses.
- Ungranted requesters see ready = 0 and must hold valid, as the AXI rules require.

## Timing
- Reset (axi_arstn = 0 at a rising edge):
  - State goes to IDLE and the round-robin pointer goes to W1.
  - Every s*/m* ready and valid output is 0.
  - m_araddr, m_awaddr, m_wdata, m_wstrb, m_arprot and m_awprot are 0.
- Reset mid-transaction abandons the transaction with no completion to the requester. The system reset must also reset the downstream slave.
- Read latency: grant in cycle N, m_arvalid in N+1. If m_arready is high in N+1, s*_rvalid can follow m_rvalid from N+2.
- Back-to-back: the handshake cycle that returns to IDLE does not arbitrate. The next grant is earliest one cycle later, so each transaction occupies at least 3 cycles.
- Requests arriving while the FSM is not IDLE wait. Pending sources are re-evaluated each IDLE cycle.
- At most one transaction is in flight; there is no reordering.

## Test plan
- Single fetch:
  - Stimulus: s0_araddr = 0x8000_0000; slave returns rdata = 0x0000_0013_0000_0013, OKAY.
  - Required: m_arprot = 3'b100, m_araddr matches, s0_rdata matches, s1_rvalid stays 0.
- Contention: R0, R1 and W1 all held continuously from reset.
  - Required: grants R0, R1, W1, R0, … in strict rotation.
  - Required: no source waits more than 2 other transactions.
- Write with skewed channels: m_awready high in cycle 1, m_wready high in cycle 4.
  - Required: m_awvalid drops after cycle 1, m_wvalid stays high through cycle 4, then B state.
  - Required: s1_bresp = 2'b10 when the slave returns SLVERR.
- Backpressure: s1_rready held 0 for 5 cycles with m_rvalid = 1.
  - Required: m_rready = 0, s1_rdata stable, FSM stays in R.
- Reset asserted mid-R:
  - Required: next cycle all valids and readies are 0, state is IDLE, pointer gives R0 first priority.
